// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  // Width of the streak counter and the latency down-counter.
  localparam int CNT_W = 4;

  // Access sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Requester identifiers latched with each grant.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times the wait for memory read data.
module arb_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data load/store onto one fixed-latency
// single-port memory, returning a one-cycle done pulse per access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(MAX_STREAK);

  arb_state_t       state, state_nxt;
  logic             winner;
  logic             we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0] streak;

  logic             any_req;
  logic             grant_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  // Data wins a tie unless it has already taken MAX_STREAK grants in a row
  // while fetch was waiting; a lone requester always wins.
  assign any_req = if_req | d_req;
  assign grant_d = d_req & (~if_req | (streak != STREAK_LIM));

  arb_lat_counter u_lat_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and latency counter control.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        cnt_load  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        cnt_dec = (cnt_value != '0);
        if (cnt_zero) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, streak tracking and read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      winner  <= REQ_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      streak  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (grant_d) begin
              winner  <= REQ_D;
              we_q    <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              streak  <= if_req ? sat_inc(streak, STREAK_LIM) : '0;
            end else begin
              winner  <= REQ_IF;
              we_q    <= 1'b0;
              addr_q  <= if_addr;
              wdata_q <= '0;
              streak  <= '0;
            end
          end
        end
        WAIT: begin
          if (cnt_zero) rdata_q <= we_q ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and requester responses decoded from state.
  always_comb begin
    mem_en    = (state == ISSUE);
    mem_we    = mem_en & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_done   = (state == RESP) && (winner == REQ_IF);
    d_done    = (state == RESP) && (winner == REQ_D);
    if_rdata  = if_done ? rdata_q : '0;
    d_rdata   = d_done ? rdata_q : '0;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a (latency 1, streak limit 2) and dut_b (latency 3,
// streak limit 4) share requester inputs, each with its own memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        a_if_done, a_d_done, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_done, b_d_done, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] mema [0:255];
  logic [31:0] memb [0:255];
  logic [31:0] a_rd;
  logic [31:0] b_p0, b_p1, b_p2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_STREAK(2)) dut_a (
    .clock(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(a_if_done), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(a_d_done), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_STREAK(4)) dut_b (
    .clock(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(b_d_done), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Latency-1 memory: data valid only in the cycle after the strobe.
  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mema[a_mem_addr[9:2]] <= a_mem_wdata;
    a_rd <= a_mem_en ? mema[a_mem_addr[9:2]] : 32'hBAD0_0001;
  end
  assign a_mem_rdata = a_rd;

  // Latency-3 memory: data valid only in the third cycle after the strobe.
  always @(posedge clk) begin
    if (b_mem_en && b_mem_we) memb[b_mem_addr[9:2]] <= b_mem_wdata;
    b_p0 <= b_mem_en ? memb[b_mem_addr[9:2]] : 32'hBAD0_0002;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && (a_busy || b_busy); i++) tick();
    chk("idle_reached", {31'b0, a_busy | b_busy}, 32'd0);
  endtask

  logic [31:0] t3_addr [6];
  logic        t3_is_d [6];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mema[i] = 32'hA500_0000 | (i << 2);
      memb[i] = 32'hA500_0000 | (i << 2);
    end
    mema[1] = 32'h2008_0005;
    memb[1] = 32'h2008_0005;
    t3_addr = '{32'h100, 32'h104, 32'h00C, 32'h108, 32'h10C, 32'h00C};
    t3_is_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_mem_en", {31'b0, a_mem_en}, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_done", {30'b0, a_if_done, a_d_done}, 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'd0);
    chk("rst_mem_wdata", a_mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // 1: single fetch, L=1: mem_en in cycle k, if_done in k+2
    if_req = 1'b1; if_addr = 32'h4;
    tick();
    chk("t1_mem_en", {31'b0, a_mem_en}, 32'd1);
    chk("t1_mem_addr", a_mem_addr, 32'h4);
    chk("t1_mem_we", {31'b0, a_mem_we}, 32'd0);
    chk("t1_busy", {31'b0, a_busy}, 32'd1);
    tick();
    chk("t1_en_one_cycle", {31'b0, a_mem_en}, 32'd0);
    chk("t1_no_early_done", {31'b0, a_if_done}, 32'd0);
    tick();
    chk("t1_if_done", {31'b0, a_if_done}, 32'd1);
    chk("t1_if_rdata", a_if_rdata, 32'h2008_0005);
    chk("t1_no_d_done", {31'b0, a_d_done}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("t1_back_idle", {31'b0, a_busy}, 32'd0);
    chk("t1_done_pulse", {31'b0, a_if_done}, 32'd0);
    wait_idle();

    // 2: simultaneous requests; data first, fetch MEM_LATENCY+3 cycles later
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick();
    chk("t2_data_first", a_mem_addr, 32'h100);
    tick(); tick();
    chk("t2_d_done", {31'b0, a_d_done}, 32'd1);
    chk("t2_d_rdata", a_d_rdata, 32'hA500_0100);
    chk("t2_if_not_done", {31'b0, a_if_done}, 32'd0);
    d_req = 1'b0;
    tick();
    chk("t2_bubble", {31'b0, a_busy}, 32'd0);
    tick();
    chk("t2_if_grant", a_mem_addr, 32'h8);
    chk("t2_if_mem_en", {31'b0, a_mem_en}, 32'd1);
    tick(); tick();
    chk("t2_if_done", {31'b0, a_if_done}, 32'd1);
    chk("t2_if_rdata", a_if_rdata, 32'hA500_0008);
    if_req = 1'b0;
    wait_idle();

    // 3: streak limit 2 with both held: D,D,IF,D,D,IF
    if_req = 1'b1; if_addr = 32'hC;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick();
    for (int g = 0; g < 6; g++) begin
      for (int n = 0; n < 20 && !a_mem_en; n++) tick();
      chk("t3_grant_seen", {31'b0, a_mem_en}, 32'd1);
      chk("t3_grant_addr", a_mem_addr, t3_addr[g]);
      tick(); tick();
      chk("t3_d_done", {31'b0, a_d_done}, {31'b0, t3_is_d[g]});
      chk("t3_if_done", {31'b0, a_if_done}, {31'b0, ~t3_is_d[g]});
      chk("t3_rdata", t3_is_d[g] ? a_d_rdata : a_if_rdata, 32'hA500_0000 | t3_addr[g]);
      if (t3_is_d[g]) d_addr = d_addr + 32'h4;
      if (g == 5) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end
      tick();
    end
    wait_idle();

    // 4: store then load back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t4_mem_en", {31'b0, a_mem_en}, 32'd1);
    chk("t4_mem_we", {31'b0, a_mem_we}, 32'd1);
    chk("t4_mem_addr", a_mem_addr, 32'h200);
    chk("t4_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("t4_we_dropped", {31'b0, a_mem_we}, 32'd0);
    tick();
    chk("t4_st_done", {31'b0, a_d_done}, 32'd1);
    chk("t4_st_rdata", a_d_rdata, 32'd0);
    d_we = 1'b0;
    tick();
    chk("t4_idle_we", {31'b0, a_mem_we}, 32'd0);
    tick();
    chk("t4_ld_en", {31'b0, a_mem_en}, 32'd1);
    chk("t4_ld_we", {31'b0, a_mem_we}, 32'd0);
    tick(); tick();
    chk("t4_ld_done", {31'b0, a_d_done}, 32'd1);
    chk("t4_ld_rdata", a_d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    wait_idle();

    // 5: L=3, reset during WAIT aborts; held request reissued
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    tick();
    chk("t5_issue", {31'b0, b_mem_en}, 32'd1);
    tick();
    chk("t5_in_wait", {30'b0, b_busy, b_mem_en}, 32'd2);
    rst = 1'b1;
    tick();
    chk("t5_rst_busy", {31'b0, b_busy}, 32'd0);
    chk("t5_rst_mem_en", {31'b0, b_mem_en}, 32'd0);
    chk("t5_rst_no_done", {30'b0, b_d_done, a_d_done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t5_reissue", {31'b0, b_mem_en}, 32'd1);
    chk("t5_reissue_addr", b_mem_addr, 32'h104);
    tick();
    chk("t5_wait1", {31'b0, b_d_done}, 32'd0);
    tick(); tick();
    chk("t5_wait3", {31'b0, b_d_done}, 32'd0);
    tick();
    chk("t5_done", {31'b0, b_d_done}, 32'd1);
    chk("t5_rdata", b_d_rdata, 32'hA500_0104);
    d_req = 1'b0;
    wait_idle();

    // 6: requester changes during WAIT are ignored
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h108;
    tick();
    chk("t6_addr", b_mem_addr, 32'h108);
    tick();
    d_req = 1'b0; d_addr = 32'h1F0; if_req = 1'b1; if_addr = 32'h20;
    tick();
    chk("t6_addr_held", b_mem_addr, 32'h108);
    chk("t6_no_en", {31'b0, b_mem_en}, 32'd0);
    d_req = 1'b1;
    tick();
    chk("t6_no_early", {30'b0, b_if_done, b_d_done}, 32'd0);
    tick();
    chk("t6_done_owner", {30'b0, b_if_done, b_d_done}, 32'd1);
    chk("t6_rdata", b_d_rdata, 32'hA500_0108);
    d_req = 1'b0; if_req = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
